// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with mid-bit sampling feeding a show-ahead FIFO.
// Sticky overflow/framing flags report dropped or corrupt bytes to software.
module uart_rx_buffer #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  output logic [7:0]                 data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       framing_error,
  input  logic                       clear_errors
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME + 1);
  localparam int PTR_W            = $clog2(DEPTH);
  localparam int OCC_W            = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE     = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             sync_p0, sync_in;
  logic             stop_sample, push, frame_err_set;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             full, empty, pop, wr_en, ovf_set;

  // Stage p0/p1: two-flop synchronizer, preset to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_in <= 1'b1;
    end else begin
      sync_p0 <= serial_in;
      sync_in <= sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      cyc_cnt <= cyc_cnt_next;
      bit_idx <= bit_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

  always_comb begin
    state_next   = state;
    cyc_cnt_next = cyc_cnt + CNT_ONE;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    case (state)
      IDLE: begin
        cyc_cnt_next = '0;
        if (!sync_in) state_next = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches
        if (cyc_cnt == SAMPLE_LAST) begin
          cyc_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = sync_in ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_cnt == SYMBOL_LAST) begin
          cyc_cnt_next = '0;
          shift_next   = {sync_in, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cyc_cnt == SYMBOL_LAST) begin
          cyc_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stop_sample   = (state == STOP) && (cyc_cnt == SYMBOL_LAST);
    push          = stop_sample && sync_in;
    frame_err_set = stop_sample && !sync_in;
  end

  // Stage p2: FIFO; a pop in the push cycle frees the slot even when full
  assign full           = (count == OCC_FULL);
  assign empty          = (count == '0);
  assign data_out_valid = !empty;
  assign data_out       = empty ? 8'h00 : mem[rd_ptr];
  assign pop            = data_out_valid && data_out_ready;
  assign wr_en          = push && (!full || pop);
  assign ovf_set        = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
      // A set event in the same cycle as clear_errors keeps the flag raised
      overflow      <= ovf_set | (overflow & ~clear_errors);
      framing_error <= frame_err_set | (framing_error & ~clear_errors);
    end
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Serial receive front end that sits directly upstream of the CPU's memory-mapped UART receive register; consumes the raw serial_in line and feeds received bytes to the CPU.
- 8N1 UART receiver, mid-bit sampling, plus a show-ahead FIFO exposed through a ready/valid interface.
- Sticky overflow and framing-error flags let software detect lost or corrupt bytes.

Parameters:
- CLOCK_FREQ, 50_000_000, clk frequency in Hz
- BAUD_RATE, 115_200, serial bit rate
- DEPTH, 8, FIFO entries; power of 2, minimum 2
- Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division); SAMPLE_TIME = SYMBOL_EDGE_TIME / 2

Ports:
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous reset, active-low (rst == 0 resets on posedge clk)
- serial_in  in  1  asynchronous UART line, idle high
- data_out  out  8  FIFO head byte; valid only while data_out_valid
- data_out_valid  out  1  FIFO non-empty
- data_out_ready  in  1  consumer pops the head when high with valid
- count  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full
- framing_error  out  1  sticky: stop bit sampled low
- clear_errors  in  1  one-cycle pulse; clears both sticky flags

Behaviour:
- Reset (rst == 0):
  - FSM goes to IDLE; FIFO is emptied.
  - Outputs: data_out_valid = 0, count = 0, overflow = 0, framing_error = 0, data_out = 8'h00.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the partial byte; nothing is pushed.
- Input sync:
  - serial_in passes through a 2-flop synchronizer; the FSM sees sync_in.
  - sync_in lags serial_in by 2 cycles.
- FSM states:
  - IDLE: when sync_in == 0, go to START and clear the cycle counter.
  - START: at counter == SAMPLE_TIME-1, sample sync_in.
    - 1: false start; return to IDLE, no flags.
    - 0: go to DATA with bit index 0; counter restarts.
  - DATA: every SYMBOL_EDGE_TIME cycles, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after SYMBOL_EDGE_TIME cycles, sample the stop bit.
    - 1: push the byte.
    - 0: set framing_error; discard the byte.
    - In both cases return to IDLE the following cycle.
- Timing:
  - Each data sample lands SYMBOL_EDGE_TIME after the previous sample, i.e. at the bit midpoint.
  - data_out_valid rises on the cycle after the push cycle.
- FIFO (show-ahead):
  - data_out always reflects the head entry.
  - Pop when data_out_valid && data_out_ready.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Full/empty are derived from count.
- Push while full, no pop: byte dropped, overflow set, count unchanged.
- Push while full with a pop in the same cycle: pop and push both take effect, count stays DEPTH, no overflow.
- Push while empty with data_out_ready high: the byte is written. The pop cannot occur until the next cycle, because valid was 0 in the push cycle.
- data_out_ready while empty: ignored; no underflow and no pointer movement.
- clear_errors with a simultaneous new error event: the set wins and the flag stays 1.
- Flags change only on reset, clear_errors, or their set event.

Test Plan:
- Byte 8'hA5 sent at 115200 baud (434 cycles/bit at 50 MHz), data_out_ready = 0 -> about 10 bit times after the start edge: data_out_valid = 1, data_out = 8'hA5, count = 1. Assert data_out_ready for one cycle -> valid = 0, count = 0.
- Four back-to-back frames 8'h01, 8'h80, 8'hFF, 8'h00 with no idle gap -> count = 4; popping one per cycle yields them in order; no flags set.
- DEPTH = 8, nine frames 8'h10..8'h18, no pops -> count = 8, overflow = 1, pops return 8'h10..8'h17. Pulse clear_errors -> overflow = 0.
- Frame 8'h3C with stop bit driven 0 -> framing_error = 1, count stays 0. A following good frame 8'h3C is received normally and framing_error stays 1.
- 100-cycle low glitch on serial_in -> FSM returns to IDLE; no push, no flags.
- Reset pulse (rst = 0 for 2 cycles) during data bit 4 of a frame, then a fresh frame 8'h5A -> count = 0 after reset; a single entry 8'h5A is then received.
- FIFO holding 8 entries, pop asserted on the exact push cycle of a 9th byte -> count stays 8, overflow = 0, new byte is last in order.
